// File: rtl/bcd_counter_display.sv
// Debounced up/down/clear BCD counter driving a multiplexed, active-low 7-segment display.
// Buttons are synchronized, debounced and edge-detected; the display scans one digit at a time.
module bcd_counter_display #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned SCAN_CYCLES = 50000,
  parameter int unsigned WRAP        = 1,
  parameter int unsigned BLANK_LZ    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_clr,
  output logic [6:0]          seg_out,
  output logic [N_DIGITS-1:0] an
);

  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W  = 4 * N_DIGITS;

  // Button bit order: [0]=up, [1]=down, [2]=clr
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d, deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];
  logic [2:0]       ev;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inc_val, dec_val;
  logic             carry, borrow, is_max, is_zero;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        cur_digit;
  logic [N_DIGITS-1:0] lz_vec;
  logic              lz_run, blank;
  logic [6:0]        seg_d;
  logic [N_DIGITS-1:0] an_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A run counter only advances while the synchronized level disagrees with the accepted level.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[i]     = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  assign ev = deb_q & ~deb_prev_q;

  always_comb begin
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    is_max  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) is_max = 1'b0;
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    is_zero = (count_q == '0);
  end

  always_comb begin
    count_d = count_q;
    if (ev[2]) begin
      count_d = '0;
    end else if (ev[0] && !ev[1]) begin
      count_d = (is_max && WRAP == 0) ? count_q : inc_val;
    end else if (ev[1] && !ev[0]) begin
      count_d = (is_zero && WRAP == 0) ? count_q : dec_val;
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // lz_vec[i] is set when digit i and every digit above it are zero.
  always_comb begin
    lz_run = 1'b1;
    lz_vec = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run    = lz_run && (count_q[4*i +: 4] == 4'd0);
      lz_vec[i] = lz_run;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    blank     = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = count_q[4*i +: 4];
        blank     = (BLANK_LZ != 0) && (i != 0) && lz_vec[i];
      end
    end
    seg_d = blank ? 7'b1111111 : seg_decode(cur_digit);
    an_d  = ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      count_q    <= '0;
      scan_q     <= '0;
      idx_q      <= '0;
      seg_out    <= 7'b1000000;
      an         <= ~N_DIGITS'(1);
    end else begin
      sync1_q    <= {btn_clr, btn_down, btn_up};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      count_q    <= count_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      seg_out    <= seg_d;
      an         <= an_d;
    end
  end

endmodule

// File: doc/bcd_counter_display.md
BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, meaning the number of BCD digits and display positions (legal range 1..8).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 250000, meaning the consecutive stable clocks a button level needs before it is accepted.
REQ-003 The block SHALL have parameter SCAN_CYCLES, default 50000, meaning the clocks each digit is driven during display scan.
REQ-004 The block SHALL have parameter WRAP, default 1, meaning 1 = wrap at the limits and 0 = saturate at the limits.
REQ-005 The block SHALL have parameter BLANK_LZ, default 0, meaning 1 = blank leading zeros.
REQ-006 Port: clk  input  1  the single clock; all logic SHALL be in this domain.
REQ-007 Port: reset  input  1  asynchronous, active-low reset.
REQ-008 Port: btn_up  input  1  raw increment button, active-high, asynchronous to clk.
REQ-009 Port: btn_down  input  1  raw decrement button, active-high, asynchronous.
REQ-010 Port: btn_clr  input  1  raw clear button, active-high, asynchronous.
REQ-011 Port: seg_out  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 Port: an  output  N_DIGITS  digit enables, active-low one-hot, registered; an[0] = least-significant digit.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each debouncer SHALL update its debounced level only after the synchronized input differs from it for DEB_CYCLES consecutive clocks; any mismatch-free cycle SHALL reset the run counter.
REQ-015 A 0->1 transition of a debounced level SHALL produce exactly one single-clock event pulse; holding a button SHALL NOT repeat the event.
REQ-016 Event priority in one clock SHALL be: clr > (up and down together = no change) > up > down.
REQ-017 The count SHALL be N_DIGITS BCD digits, range 0 to 10^N_DIGITS-1, and each digit SHALL always hold 0..9.
REQ-018 An up event SHALL add 1 with decimal carry across digits, e.g. 0199 -> 0200.
REQ-019 A down event SHALL subtract 1 with decimal borrow, e.g. 0200 -> 0199.
REQ-020 With WRAP=1, up at the maximum SHALL give 0 and down at 0 SHALL give the maximum.
REQ-021 With WRAP=0, the count SHALL hold at the maximum on up and at 0 on down.
REQ-022 A clr event SHALL set the count to 0.
REQ-023 The count SHALL update on the clock edge after the event pulse.
REQ-024 The scan timer SHALL count 0..SCAN_CYCLES-1.
REQ-025 At terminal count the digit index SHALL advance 0,1,...,N_DIGITS-1,0.
REQ-026 On the clock after the index changes, an SHALL drive the bit at the index low and all other bits high.
REQ-027 On the same clock as REQ-026, seg_out SHALL drive the decoded current value of the indexed digit.
REQ-028 Decode (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-029 With BLANK_LZ=1, digits above the most-significant non-zero digit SHALL show seg_out=1111111; digit 0 SHALL never be blanked.
REQ-030 A count change SHALL be visible the next time its digit is scanned, with no other latency.

Reset
REQ-031 While reset=0, the count, debounced levels, synchronizers, run counters, scan timer and digit index SHALL be 0.
REQ-032 While reset=0, an SHALL be all ones except an[0]=0, and seg_out SHALL be 1000000.
REQ-033 Reset assertion mid-debounce or mid-scan SHALL abort immediately with no event emitted.
REQ-034 Reset release SHALL take effect at the next clock edge; a button held through reset release SHALL produce one event after DEB_CYCLES stable clocks.

Verification (N_DIGITS=2, DEB_CYCLES=4, SCAN_CYCLES=8)
REQ-035 Bench SHALL check: btn_up glitch high for 3 clocks, then low -> count stays 00, no event.
REQ-036 Bench SHALL check: btn_up held 20 clocks -> exactly one increment, count 01.
REQ-037 Bench SHALL check: count 99, WRAP=1, one up -> 00; count 00, one down -> 99.
REQ-038 Bench SHALL check: WRAP=0, count 99, up -> 99; count 00, down -> 00.
REQ-039 Bench SHALL check: count 47, btn_up and btn_down debounced in the same clock -> 47; clr with up -> 00.
REQ-040 Bench SHALL check: count 05, BLANK_LZ=1, scan -> an=10 with seg_out=0010010 for 8 clocks, then an=01 with seg_out=1111111 for 8 clocks; reset=0 mid-scan -> an=10 and seg_out=1000000 immediately.
